serial_transmitter_neg_load_8bit: RTL and testbench

- Parallel-in, serial-out framed transmitter: drains a word captured through an active-low load enable.
- A word is captured and shifted onto one line as: start bit, data LSB first, optional parity, stop bit.
- Counterpart to the load-enabled register family: the registers accept parallel data, and this block emits it serially to a downstream receiver.

---
 rtl/serial_transmitter_neg_load_8bit.sv | 148 ++++++++++++++
 tb/tb_serial_transmitter_neg_load_8bit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_transmitter_neg_load_8bit.sv
// Framed parallel-in/serial-out transmitter: start bit, data LSB first, optional parity, stop bit.
// All state changes on the falling edge of ClkN, with a synchronous active-low clear.
module serial_transmitter_neg_load_8bit #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DIVISOR    = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             ClkN,
    input  logic             ClrN,
    input  logic [WIDTH-1:0] D,
    input  logic             Enbar,
    output logic             TxD,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DivW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    state_t            stateQ, stateD;
    logic [WIDTH-1:0]  shiftQ, shiftD;
    logic [BitW-1:0]   bitCntQ, bitCntD;
    logic [DivW-1:0]   divCntQ, divCntD;
    logic              parityQ, parityD;
    logic              txQ, txD;
    logic              busyQ, busyD;
    logic              doneQ, doneD;

    logic              bitEnd;
    logic              lastBit;
    logic              load;
    logic [WIDTH-1:0]  shiftNext;

    assign bitEnd    = (divCntQ == DivW'(DIVISOR - 1));
    assign lastBit   = (bitCntQ == BitW'(WIDTH - 1));
    assign load      = !Enbar;
    assign shiftNext = shiftQ >> 1;

    // State register
    always_ff @(negedge ClkN) begin
        if (!ClrN) begin
            stateQ  <= StIdle;
            shiftQ  <= '0;
            bitCntQ <= '0;
            divCntQ <= '0;
            parityQ <= 1'b0;
            txQ     <= 1'b1;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            shiftQ  <= shiftD;
            bitCntQ <= bitCntD;
            divCntQ <= divCntD;
            parityQ <= parityD;
            txQ     <= txD;
            busyQ   <= busyD;
            doneQ   <= doneD;
        end
    end

    // Next-state logic
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle:   if (load) stateD = StStart;
            StStart:  if (bitEnd) stateD = StData;
            StData: begin
                if (bitEnd && lastBit) stateD = (PARITY_EN != 0) ? StParity : StStop;
            end
            StParity: if (bitEnd) stateD = StStop;
            StStop:   if (bitEnd) stateD = load ? StStart : StIdle;
            default:  stateD = StIdle;
        endcase
    end

    // Datapath and registered outputs; TxD is set one edge ahead of the bit it carries
    always_comb begin
        shiftD  = shiftQ;
        bitCntD = bitCntQ;
        parityD = parityQ;
        txD     = txQ;
        busyD   = busyQ;
        doneD   = 1'b0;
        if (stateQ == StIdle || bitEnd) begin
            divCntD = '0;
        end else begin
            divCntD = divCntQ + DivW'(1);
        end
        unique case (stateQ)
            StIdle: begin
                txD   = 1'b1;
                busyD = 1'b0;
                if (load) begin
                    shiftD  = D;
                    parityD = (^D) ^ (PARITY_ODD != 0);
                    bitCntD = '0;
                    txD     = 1'b0;
                    busyD   = 1'b1;
                end
            end
            StStart: begin
                if (bitEnd) txD = shiftQ[0];
            end
            StData: begin
                if (bitEnd) begin
                    if (lastBit) begin
                        txD = (PARITY_EN != 0) ? parityQ : 1'b1;
                    end else begin
                        shiftD  = shiftNext;
                        bitCntD = bitCntQ + BitW'(1);
                        txD     = shiftNext[0];
                    end
                end
            end
            StParity: begin
                if (bitEnd) txD = 1'b1;
            end
            StStop: begin
                txD = 1'b1;
                if (bitEnd) begin
                    doneD = 1'b1;
                    if (load) begin
                        shiftD  = D;
                        parityD = (^D) ^ (PARITY_ODD != 0);
                        bitCntD = '0;
                        txD     = 1'b0;
                        busyD   = 1'b1;
                    end else begin
                        busyD = 1'b0;
                    end
                end
            end
            default: begin
                txD   = 1'b1;
                busyD = 1'b0;
            end
        endcase
    end

    assign TxD  = txQ;
    assign Busy = busyQ;
    assign Done = doneQ;

endmodule

// File: tb/tb_serial_transmitter_neg_load_8bit.sv
// Directed bench: four parameterisations share one clock; outputs sampled 1 time unit after
// each falling edge, where the next inputs are also driven.
module tb_serial_transmitter_neg_load_8bit;

    logic       clk = 1'b1;
    logic       clr [4];
    logic       enb [4];
    logic [7:0] d   [4];
    wire        tx  [4];
    wire        busy[4];
    wire        done[4];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    serial_transmitter_neg_load_8bit #(.WIDTH(8), .DIVISOR(4), .PARITY_EN(0), .PARITY_ODD(0))
        u0 (.ClkN(clk), .ClrN(clr[0]), .D(d[0]), .Enbar(enb[0]),
            .TxD(tx[0]), .Busy(busy[0]), .Done(done[0]));
    serial_transmitter_neg_load_8bit #(.WIDTH(8), .DIVISOR(4), .PARITY_EN(1), .PARITY_ODD(0))
        u1 (.ClkN(clk), .ClrN(clr[1]), .D(d[1]), .Enbar(enb[1]),
            .TxD(tx[1]), .Busy(busy[1]), .Done(done[1]));
    serial_transmitter_neg_load_8bit #(.WIDTH(8), .DIVISOR(4), .PARITY_EN(1), .PARITY_ODD(1))
        u2 (.ClkN(clk), .ClrN(clr[2]), .D(d[2]), .Enbar(enb[2]),
            .TxD(tx[2]), .Busy(busy[2]), .Done(done[2]));
    serial_transmitter_neg_load_8bit #(.WIDTH(8), .DIVISOR(1), .PARITY_EN(0), .PARITY_ODD(0))
        u3 (.ClkN(clk), .ClrN(clr[3]), .D(d[3]), .Enbar(enb[3]),
            .TxD(tx[3]), .Busy(busy[3]), .Done(done[3]));

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // pat[0] is the start bit, then each following bit in line order, ending with stop.
    task automatic frame(input int u, input int dv, input int n, input logic [10:0] pat,
                         input logic [7:0] data, input bit doLoad, input bit noise,
                         input bit reload, input logic [7:0] nextD);
        if (doLoad) begin
            d[u]   = data;
            enb[u] = 1'b0;
            tick();
        end
        enb[u] = 1'b1;
        d[u]   = 8'h00;
        for (int k = 0; k < n * dv; k++) begin
            check($sformatf("u%0d tx k%0d", u, k), tx[u], pat[k / dv]);
            check($sformatf("u%0d busy k%0d", u, k), busy[u], 1'b1);
            if (doLoad || k > 0) check($sformatf("u%0d done k%0d", u, k), done[u], 1'b0);
            if (noise && k >= 4 && k < 20) begin
                enb[u] = 1'b0;
                d[u]   = 8'hFF;
            end else begin
                enb[u] = 1'b1;
            end
            if (reload && k == n * dv - 1) begin
                enb[u] = 1'b0;
                d[u]   = nextD;
            end
            tick();
        end
        enb[u] = 1'b1;
        check($sformatf("u%0d done end", u), done[u], 1'b1);
        check($sformatf("u%0d busy end", u), busy[u], reload);
        check($sformatf("u%0d tx end", u), tx[u], !reload);
        if (!reload) begin
            tick();
            check($sformatf("u%0d done after", u), done[u], 1'b0);
            check($sformatf("u%0d busy after", u), busy[u], 1'b0);
            check($sformatf("u%0d tx after", u), tx[u], 1'b1);
        end
    endtask

    initial begin
        for (int u = 0; u < 4; u++) begin
            clr[u] = 1'b0;
            enb[u] = 1'b1;
            d[u]   = 8'h00;
        end
        tick();
        tick();
        for (int u = 0; u < 4; u++) begin
            check($sformatf("u%0d reset tx", u), tx[u], 1'b1);
            check($sformatf("u%0d reset busy", u), busy[u], 1'b0);
            check($sformatf("u%0d reset done", u), done[u], 1'b0);
            clr[u] = 1'b1;
        end
        tick();

        // A5, no parity, divisor 4
        frame(0, 4, 10, 11'b0_1_10100101_0, 8'hA5, 1, 0, 0, 8'h00);
        // 07 with even parity -> 1, odd parity -> 0
        frame(1, 4, 11, 11'b1_1_00000111_0, 8'h07, 1, 0, 0, 8'h00);
        frame(2, 4, 11, 11'b1_0_00000111_0, 8'h07, 1, 0, 0, 8'h00);
        // Load requests and D changes mid-frame are ignored
        frame(0, 4, 10, 11'b0_1_10100101_0, 8'hA5, 1, 1, 0, 8'h00);
        // Back-to-back: reload 3C on the final stop edge
        frame(0, 4, 10, 11'b0_1_10100101_0, 8'hA5, 1, 0, 1, 8'h3C);
        frame(0, 4, 10, 11'b0_1_00111100_0, 8'h00, 0, 0, 0, 8'h00);
        // Divisor 1, 80
        frame(3, 1, 10, 11'b0_1_10000000_0, 8'h80, 1, 0, 0, 8'h00);

        // Reset during data bit 3 (line bit 4 covers edges 16..19 after load)
        d[0]   = 8'hA5;
        enb[0] = 1'b0;
        tick();
        enb[0] = 1'b1;
        for (int k = 0; k < 17; k++) tick();
        check("mid-frame tx before clear", tx[0], 1'b0);
        clr[0] = 1'b0;
        tick();
        clr[0] = 1'b1;
        check("clear tx", tx[0], 1'b1);
        check("clear busy", busy[0], 1'b0);
        check("clear done", done[0], 1'b0);
        for (int k = 0; k < 24; k++) begin
            tick();
            check($sformatf("post-clear done k%0d", k), done[0], 1'b0);
            check($sformatf("post-clear busy k%0d", k), busy[0], 1'b0);
        end

        // Clear and load together: clear wins
        clr[0] = 1'b0;
        enb[0] = 1'b0;
        d[0]   = 8'h3C;
        tick();
        check("clr+load busy", busy[0], 1'b0);
        check("clr+load tx", tx[0], 1'b1);
        clr[0] = 1'b1;
        enb[0] = 1'b1;
        tick();
        check("clr+load stays idle busy", busy[0], 1'b0);
        check("clr+load stays idle tx", tx[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
